// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the CPU top-level: state encoding and size defaults.
// The VERIFY state only exists when PROG_LOADER_VERIFY_EN is defined.
package prog_loader_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_WRITE,
`ifdef PROG_LOADER_VERIFY_EN
    ST_VERIFY,
`endif
    ST_DONE
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams DEPTH host bytes into RAM over the shared bus, one byte per two cycles.
// Define PROG_LOADER_VERIFY_EN to add a readback pass that compares the bus sum to the checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_abort,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [AW-1:0] ld_addr,
  output logic          ld_active,
  output logic          ram_write,
  output logic          ram_read,
  inout  wire  [DW-1:0] bus,
  output logic          done,
  output logic [DW-1:0] checksum,
  output logic          verify_err
);

  // Handshake: a byte moves when din_valid and din_ready are both high at a rising
  // edge; din_ready is high only while waiting for a byte, so din_valid is otherwise ignored.

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t          state;
  logic [AW-1:0]   count;
  logic [DW-1:0]   byte_q;
  logic            drive;

`ifdef PROG_LOADER_VERIFY_EN
  logic [DW-1:0]   vsum;
`endif

  // Bus is driven only during the single WRITE cycle; drive clears asynchronously on reset.
  assign bus = drive ? byte_q : 'z;

  // Loader owns the RAM address while active; the CPU address path parks at zero here.
  assign ld_addr = ld_active ? count : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      byte_q     <= '0;
      checksum   <= '0;
      done       <= 1'b0;
      din_ready  <= 1'b0;
      ld_active  <= 1'b0;
      ram_write  <= 1'b0;
      drive      <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
      vsum       <= '0;
      ram_read   <= 1'b0;
      verify_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state      <= ST_WAIT_BYTE;
            count      <= '0;
            checksum   <= '0;
            done       <= 1'b0;
            din_ready  <= 1'b1;
            ld_active  <= 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
            verify_err <= 1'b0;
`endif
          end
        end
        ST_WAIT_BYTE: begin
          if (din_valid) begin
            byte_q    <= din;
            state     <= ST_WRITE;
            din_ready <= 1'b0;
            ram_write <= 1'b1;
            drive     <= 1'b1;
          end
        end
        ST_WRITE: begin
          ram_write <= 1'b0;
          drive     <= 1'b0;
          checksum  <= checksum + byte_q;
          if (count == LAST) begin
            count <= '0;
`ifdef PROG_LOADER_VERIFY_EN
            state    <= ST_VERIFY;
            ram_read <= 1'b1;
            vsum     <= '0;
`else
            state     <= ST_DONE;
            done      <= 1'b1;
            ld_active <= 1'b0;
`endif
          end else begin
            count     <= count + 1'b1;
            state     <= ST_WAIT_BYTE;
            din_ready <= 1'b1;
          end
        end
`ifdef PROG_LOADER_VERIFY_EN
        ST_VERIFY: begin
          vsum <= vsum + bus;
          if (count == LAST) begin
            count      <= '0;
            verify_err <= (vsum + bus) != checksum;
            state      <= ST_DONE;
            done       <= 1'b1;
            ld_active  <= 1'b0;
            ram_read   <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Abort wins over everything; a write already on the bus this cycle still lands.
      if (load_abort) begin
        state     <= ST_IDLE;
        done      <= 1'b0;
        din_ready <= 1'b0;
        ld_active <= 1'b0;
        ram_write <= 1'b0;
        drive     <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
        ram_read  <= 1'b0;
`endif
      end
    end
  end

`ifndef PROG_LOADER_VERIFY_EN
  assign ram_read   = 1'b0;
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: RAM model on the shared bus, randomized and directed loads,
// checked against a stream-level model of what each load must leave behind.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int N = 16;
  localparam logic [7:0] SENT = 8'hC3;
`ifdef PROG_LOADER_VERIFY_EN
  localparam int VLEN = 16;
`else
  localparam int VLEN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic       load_abort = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready, ld_active, ram_write, ram_read, done, verify_err;
  logic [3:0] ld_addr;
  logic [7:0] checksum;
  tri1  [7:0] bus;

  logic [7:0] mem [N];
  logic       fill_req = 1'b0;
  logic       corrupt_req = 1'b0;
  logic [7:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .ld_addr(ld_addr),
    .ld_active(ld_active), .ram_write(ram_write), .ram_read(ram_read), .bus(bus),
    .done(done), .checksum(checksum), .verify_err(verify_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model: captures bus on ram_write, returns data on ram_read
  always_ff @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < N; i++) mem[i] <= SENT;
    end else begin
      if (ram_write) mem[ld_addr] <= bus;
      if (corrupt_req) mem[5] <= mem[5] ^ 8'h01;
    end
  end
  assign bus = ram_read ? mem[ld_addr] : 'z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One load; abort_at = bytes written before aborting, dup_at = cycle of a stray load_start.
  task automatic run_load(input bit directed, input int stall_at, input int abort_at,
                          input bit rst_mid, input int dup_at, input bit corrupt);
    logic [7:0] data [N];
    logic [7:0] exp_ram [N];
    logic [7:0] exp_sum = '0;
    int acc_cnt = 0, wr_idx = 0, last_w = -100, stall_left = 0, stop_cyc = 0;
    bit acc_prev = 0, aborted = 0, finished = 0, ended = 0, in_ver = 0;
    for (int i = 0; i < N; i++) begin
      data[i]    = directed ? 8'(i) : 8'($urandom_range(0, 254));
      exp_ram[i] = SENT;
    end
    exp_q.delete();
    @(negedge clk); fill_req = 1'b1;
    @(negedge clk); fill_req = 1'b0; load_start = 1'b1; din_valid = 1'b0;
    for (int cyc = 1; cyc <= 400 && !ended; cyc++) begin
      @(negedge clk);
      load_start = 1'b0; load_abort = 1'b0; corrupt_req = 1'b0;
      finished = !aborted && (wr_idx == N) && (cyc >= last_w + 1 + VLEN);
      in_ver   = (VLEN > 0) && (wr_idx == N) && (cyc > last_w) && (cyc <= last_w + VLEN);
      check("ram_write", 32'(ram_write), 32'(acc_prev));
      check("ld_active", 32'(ld_active), 32'(!aborted && !finished));
      check("done", 32'(done), 32'(finished));
      check("ram_read", 32'(ram_read), 32'(in_ver));
      if (in_ver) check("rd_addr", 32'(ld_addr), 32'(cyc - last_w - 1));
      check("din_ready", 32'(din_ready), 32'(!aborted && !finished && !acc_prev && !in_ver));
      if (ram_write) begin
        check("wr_addr", 32'(ld_addr), 32'(wr_idx));
        check("wr_queue", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) check("wr_bus", 32'(bus), 32'(exp_q.pop_front()));
        wr_idx++;
        last_w = cyc;
        if (rst_mid && wr_idx == 5) begin
          #1 rst_n = 1'b0;
          #1;
          check("rst_bus", 32'(bus), 32'hFF);
          check("rst_wr", 32'(ram_write), 32'(0));
          check("rst_rd", 32'(ram_read), 32'(0));
          check("rst_active", 32'(ld_active), 32'(0));
          check("rst_ready", 32'(din_ready), 32'(0));
          check("rst_done", 32'(done), 32'(0));
          check("rst_sum", 32'(checksum), 32'(0));
          check("rst_verr", 32'(verify_err), 32'(0));
          din_valid = 1'b0;
          @(negedge clk); rst_n = 1'b1;
          return;
        end
      end else if (!in_ver) begin
        check("bus_z", 32'(bus), 32'hFF);
      end
      if (finished && cyc == last_w + 2 + VLEN) ended = 1;
      if (aborted && cyc >= stop_cyc) ended = 1;
      if (!ended) begin
        if (abort_at >= 0 && !aborted && ram_write && wr_idx == abort_at) begin
          load_abort = 1'b1;
          aborted    = 1;
          stop_cyc   = cyc + 3;
        end
        if (dup_at == cyc) load_start = 1'b1;
        if (corrupt && wr_idx == N && cyc == last_w) corrupt_req = 1'b1;
        if (stall_left > 0) begin
          din_valid = 1'b0;
          stall_left--;
        end else begin
          din_valid = aborted ? 1'b0 : (directed ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
        din = (acc_cnt < N) ? data[acc_cnt] : 8'($urandom);
        acc_prev = din_valid && din_ready && !load_abort && !aborted;
        if (acc_prev) begin
          exp_q.push_back(din);
          if (acc_cnt < N) exp_ram[acc_cnt] = din;
          exp_sum += din;
          acc_cnt++;
          if (acc_cnt == stall_at + 1) stall_left = 5;
        end
      end
    end
    din_valid = 1'b0;
    check("timeout", 32'(ended), 32'(1));
    if (!aborted) begin
      check("checksum", 32'(checksum), directed ? 32'h78 : 32'(exp_sum));
      check("verify_err", 32'(verify_err), 32'(corrupt));
      if (directed && stall_at < 0) check("done_cycle", 32'(last_w + 1 + VLEN), 32'(2 * N + 1 + VLEN));
      if (corrupt) exp_ram[5] = exp_ram[5] ^ 8'h01;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(exp_ram[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_active", 32'(ld_active), 32'(0));
    check("reset_ready", 32'(din_ready), 32'(0));
    check("reset_wr", 32'(ram_write), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_sum", 32'(checksum), 32'(0));
    check("reset_bus", 32'(bus), 32'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    run_load(1, -1, -1, 0, -1, 0);
    run_load(1, 3, -1, 0, -1, 0);
    run_load(1, -1, 8, 0, -1, 0);
    run_load(1, -1, -1, 1, -1, 0);
    run_load(1, -1, -1, 0, -1, 0);
    run_load(1, -1, -1, 0, 5, 0);
`ifdef PROG_LOADER_VERIFY_EN
    run_load(1, -1, -1, 0, -1, 1);
`endif
    for (int r = 0; r < 6; r++) run_load(0, int'($urandom_range(0, 14)), -1, 0, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
